// File: rtl/line_reader_pkg.sv
// line_reader_pkg: shared character codes and FSM encodings for the UART line reader
package line_reader_pkg;
  localparam logic [7:0] CHAR_NUL = 8'h00;
  localparam logic [7:0] CHAR_BS  = 8'h08;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_DEL = 8'h7F;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic {LN_COLLECT, LN_HOLD} line_state_e;
  function automatic logic is_term(input logic [7:0] c);
    return (c == CHAR_CR) || (c == CHAR_LF);
  endfunction
endpackage

// File: rtl/line_reader_uart_rx_core.sv
// uart_rx_core: 8N1 receiver with 2-flop synchroniser; ports clk, rst_n, uart_rx in; rx_byte, rx_strobe (1-cycle), frame_err (1-cycle) out
module uart_rx_core
  import line_reader_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frame_err
);
  localparam int BIT_CYC = CLK_FRE * 1_000_000 / BAUD_RATE;
  localparam int CW = $clog2(BIT_CYC + 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYC / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);
  rx_state_e     state_q, state_d;
  logic [2:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          brk_q, brk_d;
  logic          strobe_q, strobe_d;
  logic          ferr_q, ferr_d;
  logic          rx_s, fall;
  // sync_q[1] is the synchronised line; sync_q[2] is its previous value for edge detection
  assign rx_s = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];
  always_comb begin
    sync_d   = {sync_q[1:0], uart_rx};
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    data_d   = data_q;
    brk_d    = brk_q;
    strobe_d = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = RX_START;
      end
      RX_START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == LAST) begin
        cnt_d  = '0;
        data_d = {rx_s, data_q[7:1]};
        bit_d  = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = RX_STOP;
      end
      RX_STOP: begin
        // brk_q: a bad stop bit was seen; wait for the line to return high before re-arming
        if (brk_q) begin
          cnt_d = '0;
          if (rx_s) begin
            brk_d   = 1'b0;
            state_d = RX_IDLE;
          end
        end else if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            strobe_d = 1'b1;
            state_d  = RX_IDLE;
          end else begin
            ferr_d = 1'b1;
            brk_d  = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RX_IDLE;
      sync_q   <= '1;
      cnt_q    <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      brk_q    <= 1'b0;
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      brk_q    <= brk_d;
      strobe_q <= strobe_d;
      ferr_q   <= ferr_d;
    end
  end
  assign rx_byte   = data_q;
  assign rx_strobe = strobe_q;
  assign frame_err = ferr_q;
endmodule

// File: rtl/line_reader.sv
// line_reader: UART RX line assembler; ports clk, rst_n, uart_rx, line_ack in; line (char 0 in MSBs, NUL padded), line_len, line_valid, overflow (sticky), frame_err out; LINE_READER_BACKSPACE_EN enables BS/DEL editing
module line_reader
  import line_reader_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200,
  parameter int MAX_CHARS = 81
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   uart_rx,
  output logic [8*MAX_CHARS-1:0] line,
  output logic [7:0]             line_len,
  output logic                   line_valid,
  input  logic                   line_ack,
  output logic                   overflow,
  output logic                   frame_err
);
  localparam int W = 8 * MAX_CHARS;
  logic [7:0]  rx_byte;
  logic        rx_strobe;
  line_state_e state_q, state_d;
  logic [W-1:0] line_q, line_d;
  logic [7:0]  count_q, count_d;
  logic        valid_q, valid_d;
  logic        ovf_q, ovf_d;
  uart_rx_core #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD_RATE)) u_rx (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .rx_byte(rx_byte), .rx_strobe(rx_strobe), .frame_err(frame_err)
  );
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    count_d = count_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (state_q == LN_HOLD) begin
      // ack beats a simultaneous byte: the byte is lost but overflow still clears
      if (line_ack) begin
        state_d = LN_COLLECT;
        line_d  = '0;
        count_d = '0;
        valid_d = 1'b0;
        ovf_d   = 1'b0;
      end else if (rx_strobe) ovf_d = 1'b1;
    end else if (rx_strobe) begin
      if (is_term(rx_byte)) begin
        if (count_q != 8'd0) begin
          state_d = LN_HOLD;
          valid_d = 1'b1;
        end
      end else if (rx_byte == CHAR_NUL) begin
      end
`ifdef LINE_READER_BACKSPACE_EN
      else if (rx_byte == CHAR_BS || rx_byte == CHAR_DEL) begin
        if (count_q != 8'd0) begin
          line_d[W-1-8*(int'(count_q)-1) -: 8] = '0;
          count_d = count_q - 8'd1;
        end
      end
`endif
      else if (int'(count_q) < MAX_CHARS) begin
        line_d[W-1-8*int'(count_q) -: 8] = rx_byte;
        count_d = count_q + 8'd1;
      end else ovf_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LN_COLLECT;
      line_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end
  assign line       = line_q;
  assign line_len   = count_q;
  assign line_valid = valid_q;
  assign overflow   = ovf_q;
endmodule
